// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains a synchronous FIFO and packs PACK words per output beat,
// with a flush that forces out any partial beat marked m_last.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_empty,
    input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
    output logic                       fifo_rd_en,
    input  logic                       flush,
    output logic                       flush_busy,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       m_last
);
    localparam int CW = $clog2(PACK) + 1;
    localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [CW:0]   FULL_W = PACK[CW:0];
    localparam logic [CW-1:0] FULL_C = PACK[CW-1:0];

    typedef enum logic [1:0] {RUN, FL_WAIT, FL_EMIT} state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   asm_cnt_q, asm_cnt_d;
    logic [CW:0]                     cnt_land;
    logic                            inflight_q;
    logic [PACK-1:0][DATA_WIDTH-1:0] asm_q, asm_d, part;
    logic [PACK-1:0][DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [PACK-1:0]                 m_keep_q, m_keep_d, keep_part;
    logic                            m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic                            out_free, load_full, load_part;

    always_comb begin
        out_free   = !m_valid_q || m_ready;
        // Count includes the read in flight so we never over-request past one beat.
        cnt_land   = {1'b0, asm_cnt_q} + {{CW{1'b0}}, inflight_q};
        fifo_rd_en = rst_n && !fifo_empty && state_q == RUN && !flush && cnt_land < FULL_W;
        asm_d      = asm_q;
        if (inflight_q)
            asm_d[asm_cnt_q[LW-1:0]] = fifo_rd_data;
        load_full  = cnt_land == FULL_W && out_free;
        load_part  = state_q == FL_EMIT && out_free;
        keep_part  = ~({PACK{1'b1}} << asm_cnt_q);
        for (int k = 0; k < PACK; k++)
            part[k] = keep_part[k] ? asm_q[k] : '0;
        asm_cnt_d  = (load_full || load_part) ? '0 : cnt_land[CW-1:0];
        m_valid_d  = load_full || load_part || (m_valid_q && !m_ready);
        m_data_d   = load_full ? asm_d : load_part ? part : m_data_q;
        m_keep_d   = load_full ? '1 : load_part ? keep_part : m_keep_q;
        m_last_d   = load_full ? 1'b0 : load_part ? 1'b1 : m_last_q;
        // A flush waits out any in-flight read and any held full beat before deciding.
        state_d    = state_q == RUN     ? (flush ? FL_WAIT : RUN) :
                     state_q == FL_WAIT ? ((inflight_q || asm_cnt_q == FULL_C) ? FL_WAIT :
                                           (asm_cnt_q == '0) ? RUN : FL_EMIT) :
                                          (out_free ? RUN : FL_EMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            asm_cnt_q  <= '0;
            inflight_q <= 1'b0;
            asm_q      <= '0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            asm_cnt_q  <= asm_cnt_d;
            inflight_q <= fifo_rd_en;
            asm_q      <= asm_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_last_q   <= m_last_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign flush_busy = state_q != RUN;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_keep     = m_keep_q;
    assign m_last     = m_last_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: FIFO model plus word-order scoreboard for fifo_rd_packer.
module tb_fifo_rd_packer;
    localparam int DW = 8;
    localparam int PK = 4;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              fifo_empty, fifo_rd_en, flush_busy, m_valid, m_last;
    logic              flush = 1'b0, m_ready = 1'b0, force_empty = 1'b0;
    logic [DW-1:0]     fifo_rd_data = '0;
    logic [DW*PK-1:0]  m_data;
    logic [PK-1:0]     m_keep;

    logic [DW-1:0]     mem [0:4095];
    int                wr_ptr = 0, rd_ptr = 0;
    int                checks = 0, failures = 0, cyc = 0, rd_cnt = 0, words_out = 0;
    logic [DW-1:0]     exp_q [$];

    typedef struct {
        logic [DW*PK-1:0] d;
        logic [PK-1:0]    k;
        logic             l;
        int               t;
    } beat_t;
    beat_t             beats [$];

    logic              prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [PK-1:0]     prev_k = '0;
    logic [DW*PK-1:0]  prev_d = '0, exp_d;
    int                nw;

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .flush(flush), .flush_busy(flush_busy), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last)
    );

    always #5 clk = ~clk;

    assign fifo_empty = force_empty || rd_ptr == wr_ptr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr[11:0]] = w;
        wr_ptr++;
    endtask

    // FIFO read port with one-cycle latency; every popped word joins the expected stream.
    always @(posedge clk) begin
        cyc++;
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr[11:0]];
            exp_q.push_back(mem[rd_ptr[11:0]]);
            rd_ptr <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            check("rd_while_empty", {63'd0, fifo_rd_en && fifo_empty}, 64'd0);
            if (fifo_rd_en)
                rd_cnt++;
            if (prev_v && !prev_r)
                check("hold_stable", {m_valid, m_last, m_keep, m_data}, {1'b1, prev_l, prev_k, prev_d});
            if (m_valid && m_ready) begin
                nw = $countones(m_keep);
                check("beat_nonempty", {63'd0, nw > 0}, 64'd1);
                check("keep_shape", m_keep, (64'd1 << nw) - 64'd1);
                check("last_flag", m_last, (nw != PK) ? 64'd1 : 64'd0);
                check("sb_avail", {63'd0, exp_q.size() >= nw}, 64'd1);
                exp_d = '0;
                for (int k = 0; k < nw; k++)
                    if (exp_q.size() > 0)
                        exp_d[k*DW +: DW] = exp_q.pop_front();
                check("beat_data", m_data, exp_d);
                beats.push_back('{m_data, m_keep, m_last, cyc});
                words_out += nw;
            end
            prev_v = m_valid;
            prev_r = m_ready;
            prev_l = m_last;
            prev_k = m_keep;
            prev_d = m_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, r0, w0, n;
        step(3);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_keep", m_keep, 0);
        check("rst_last", m_last, 0);
        check("rst_busy", flush_busy, 0);
        check("rst_rden", fifo_rd_en, 0);
        rst_n = 1'b1;
        step(2);

        // Full beats with a free-running sink.
        b0 = beats.size(); r0 = rd_cnt; m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(DW'(8'h11 * i));
        step(25);
        check("t1_rd_count", rd_cnt - r0, 8);
        check("t1_nbeats", beats.size() - b0, 2);
        if (beats.size() >= b0 + 2) begin
            check("t1_b0_data", beats[b0].d, 32'h44332211);
            check("t1_b1_data", beats[b0+1].d, 32'h88776655);
            check("t1_b0_keep", beats[b0].k, 4'hF);
            check("t1_b1_last", beats[b0+1].l, 0);
            check("t1_spacing", beats[b0+1].t - beats[b0].t, 5);
        end

        // Backpressure: reads stop once a second beat is assembled behind the held one.
        b0 = beats.size(); r0 = rd_cnt; m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(DW'(8'h11 * i));
        step(20);
        check("t2_rd_count", rd_cnt - r0, 8);
        check("t2_nbeats_held", beats.size() - b0, 0);
        check("t2_valid_held", m_valid, 1);
        check("t2_data_held", m_data, 32'h44332211);
        m_ready = 1'b1;
        step(10);
        check("t2_nbeats", beats.size() - b0, 2);
        if (beats.size() >= b0 + 2) begin
            check("t2_b0_data", beats[b0].d, 32'h44332211);
            check("t2_b1_data", beats[b0+1].d, 32'h88776655);
            check("t2_back2back", beats[b0+1].t - beats[b0].t, 1);
        end

        // Flush of a three-word tail.
        b0 = beats.size(); r0 = rd_cnt;
        push(8'hA1); push(8'hA2); push(8'hA3);
        for (int i = 0; i < 20 && rd_cnt - r0 < 3; i++) step(1);
        check("t3_rd_count", rd_cnt - r0, 3);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("t3_busy", flush_busy, 1);
        n = 0;
        while (flush_busy && n < 20) begin n++; step(1); end
        check("t3_busy_cycles", n, 2);
        check("t3_valid_at_drop", m_valid, 1);
        step(3);
        check("t3_nbeats", beats.size() - b0, 1);
        if (beats.size() >= b0 + 1) begin
            check("t3_data", beats[b0].d, 32'h00A3A2A1);
            check("t3_keep", beats[b0].k, 4'h7);
            check("t3_last", beats[b0].l, 1);
        end

        // Flush with nothing assembled.
        step(3);
        b0 = beats.size(); r0 = rd_cnt;
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        n = 0;
        while (flush_busy && n < 20) begin n++; step(1); end
        check("t4_busy_cycles", n, 1);
        step(10);
        check("t4_nbeats", beats.size() - b0, 0);
        check("t4_rd_count", rd_cnt - r0, 0);

        // Random empty toggling, backpressure and flushes over 1000 words.
        w0 = words_out;
        for (int i = 0; i < 1000; i++) push(DW'($urandom_range(0, 255)));
        for (int i = 0; i < 20000 && words_out - w0 < 1000; i++) begin
            m_ready     = 1'($urandom_range(0, 1));
            force_empty = ~force_empty;
            flush       = ($urandom_range(0, 39) == 0);
            step(1);
        end
        flush = 1'b0; force_empty = 1'b0; m_ready = 1'b1;
        step(10);
        check("t5_words_out", words_out - w0, 1000);
        check("t5_sb_empty", exp_q.size(), 0);

        // Reset with a pending beat and two assembled words.
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(DW'(8'h30 + i));
        step(14);
        check("t6_pre_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_data", m_data, 0);
        check("t6_rst_keep", m_keep, 0);
        check("t6_rst_last", m_last, 0);
        check("t6_rst_busy", flush_busy, 0);
        exp_q.delete();
        for (int i = 1; i <= 4; i++) push(DW'(i));
        #1;
        check("t6_rst_rden", fifo_rd_en, 0);
        step(2);
        rst_n = 1'b1;
        m_ready = 1'b1;
        b0 = beats.size();
        step(12);
        check("t6_nbeats", beats.size() - b0, 1);
        if (beats.size() >= b0 + 1) begin
            check("t6_data", beats[b0].d, 32'h04030201);
            check("t6_keep", beats[b0].k, 4'hF);
            check("t6_last", beats[b0].l, 0);
        end
        check("t6_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
Read-side controller for the team's synchronous FIFO. It drains words through the FIFO read port (rd_en / rd_data / empty, one-cycle read latency) and packs PACK consecutive words into one wide beat. Beats go out on a valid/ready stream. A flush request forces out a partial beat so a packet tail is never stranded.

Parameters:
DATA_WIDTH, 8, width of one FIFO word
PACK, 4, words per output beat (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
fifo_empty  input  1  FIFO empty flag
fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
fifo_rd_en  output  1  FIFO read strobe (combinational)
flush  input  1  single-cycle request to emit any partial beat
flush_busy  output  1  high from cycle after flush until flush completes
m_valid  output  1  output beat valid
m_ready  input  1  downstream accept
m_data  output  DATA_WIDTH*PACK  packed beat; word k in bits [k*DATA_WIDTH +: DATA_WIDTH]
m_keep  output  PACK  per-word valid mask
m_last  output  1  beat produced by a flush

Behaviour:
- Reset: clk is the clock; rst_n is the reset, asynchronous, active-low. On reset all outputs are 0, state is RUN, and asm_cnt, inflight and the output register are cleared. Reset mid-beat discards partial and in-flight data.
- Internal state: assembly register of PACK words; asm_cnt (0..PACK, log2(PACK)+1 bits); inflight (1 bit, = fifo_rd_en of the previous cycle); output register (m_data/m_keep/m_last/m_valid).
- fifo_rd_en = !fifo_empty && state==RUN && !flush && (asm_cnt + inflight) < PACK.
- Data landing: when inflight=1, fifo_rd_data is written to lane asm_cnt and asm_cnt increments. The first word read goes to the lowest lane.
- Beat completion: a beat is complete when asm_cnt reaches PACK, counting the word landing this cycle.
  - If the output register is free (!m_valid, or m_valid && m_ready), the beat loads the output register in that same cycle, with the landing word included. m_keep is all ones, m_last=0, asm_cnt becomes 0.
  - Otherwise the beat is held with asm_cnt=PACK and moves on the first cycle the output register frees.
- Throughput: one idle read cycle per beat, i.e. sustained PACK words per PACK+1 cycles. PACK=1 gives one word every 2 cycles.
- Output stream: m_valid stays high until m_ready. m_data, m_keep and m_last are stable while m_valid && !m_ready. A new beat may load in the same cycle the current one is accepted, with no bubble.
- State machine:
  - RUN: normal operation. flush=1 moves to FL_WAIT.
  - FL_WAIT: no new reads. Waits for inflight=0 and for any complete beat to move to the output register.
    - If asm_cnt==0, go to RUN (flush_busy drops).
    - Else go to FL_EMIT.
  - FL_EMIT: when the output register is free, load the partial beat.
    - m_keep = (1<<asm_cnt)-1; unused lanes are zero; m_last=1.
    - asm_cnt becomes 0; go to RUN.
- flush_busy = (state != RUN).
- flush while in FL_WAIT or FL_EMIT is ignored. flush landing exactly as a beat completes: the full beat is emitted normally, with m_last=0. The flush then finds asm_cnt==0 and emits nothing.
- fifo_empty asserted while inflight=1: the in-flight word is still captured. The empty flag applies only to new reads.
- The block never issues fifo_rd_en while fifo_empty=1, and never loses or duplicates a word under any m_ready pattern.

Test Plan:
- PACK=4, FIFO preloaded with 0x11..0x88, m_ready=1 -> two beats 0x44332211 then 0x88776655, m_keep=0xF, m_last=0. Exactly 8 rd_en pulses; beats 5 cycles apart.
- Same data, m_ready held 0 for 20 cycles -> first beat held stable. Reads stop after 8 words (asm_cnt=4 with output full). Releasing m_ready yields both beats back-to-back, in order.
- Preload 0xA1,0xA2,0xA3, then pulse flush after the third rd_en -> flush_busy high. One beat 0x00A3A2A1, m_keep=0x7, m_last=1. flush_busy low the cycle after the load.
- Flush with an empty FIFO and asm_cnt=0 -> no beat, flush_busy high exactly 1 cycle, no rd_en.
- fifo_empty toggling every cycle with random m_ready, 1000 words -> reassembled output equals the input sequence. No rd_en occurs while empty.
- Assert rst_n low with 2 words assembled and a beat pending -> all outputs 0 immediately. After release, new data 0x01..0x04 yields a single beat 0x04030201.
